alu_seq: RTL and testbench

//  Parametrised sequential successor of the CPU accumulator ALU. Adds a registered

---
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential accumulator ALU with start/busy/done handshake
// Single-cycle ops resolve on accept; MUL and multi-step rotates iterate in RUN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             E,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             E_out,
  output logic             Z_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH:0] ROT_MOD = (WIDTH+1)'(WIDTH + 1);

  localparam logic [3:0] OP_INC = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_DEC = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_IOR = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_INV = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_MOV = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_RCR = 4'b1100;
  localparam logic [3:0] OP_RCL = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] work_hi_q;
  logic [WIDTH-1:0] work_lo_q;
  logic             work_e_q;
  logic [CNT_W-1:0] count_q;

  logic             is_mul;
  logic             is_rot;
  logic [CNT_W-1:0] rot_n;
  logic             multi_start;

  logic [WIDTH-1:0] sc_out;
  logic             sc_e;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             step_e;

  assign is_mul      = (opcode == OP_MUL);
  assign is_rot      = (opcode == OP_RCR) || (opcode == OP_RCL);
  assign rot_n       = CNT_W'({1'b0, b} % ROT_MOD);
  assign multi_start = is_mul || (is_rot && (rot_n != '0));

  // Single-cycle result; a rotate by zero positions is a plain pass-through.
  always_comb begin
    sc_out = '0;
    sc_e   = E;
    case (opcode)
      OP_INC: sc_out = a + 1'b1;
      OP_ADD: {sc_e, sc_out} = {1'b0, a} + {1'b0, b};
      OP_SUB: {sc_e, sc_out} = {1'b0, a} - {1'b0, b};
      OP_DEC: sc_out = a - 1'b1;
      OP_AND: sc_out = a & b;
      OP_IOR: sc_out = a | b;
      OP_XOR: sc_out = a ^ b;
      OP_INV: sc_out = ~a;
      OP_SHR: {sc_e, sc_out} = {a[0], E, a[WIDTH-1:1]};
      OP_SHL: {sc_e, sc_out} = {a[WIDTH-1], a[WIDTH-2:0], E};
      OP_MOV: sc_out = a;
      OP_RCR: sc_out = a;
      OP_RCL: sc_out = a;
      default: sc_out = '0;
    endcase
  end

  // MUL keeps {work_hi, work_lo} as the partial product with the multiplier
  // draining out of work_lo; rotates treat {work_e, work_lo} as one ring.
  assign mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opa_q} : '0);

  always_comb begin
    step_hi = work_hi_q;
    step_lo = work_lo_q;
    step_e  = work_e_q;
    case (op_q)
      OP_MUL: begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
      end
      OP_RCR: begin
        step_e  = work_lo_q[0];
        step_lo = {work_e_q, work_lo_q[WIDTH-1:1]};
      end
      OP_RCL: begin
        step_e  = work_lo_q[WIDTH-1];
        step_lo = {work_lo_q[WIDTH-2:0], work_e_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = multi_start ? RUN : DONE;
      RUN:     if (count_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      opa_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      work_e_q  <= 1'b0;
      count_q   <= '0;
      alu_out   <= '0;
      alu_hi    <= '0;
      E_out     <= 1'b0;
      Z_out     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= opcode;
            opa_q     <= a;
            work_hi_q <= '0;
            work_lo_q <= is_mul ? b : a;
            work_e_q  <= E;
            count_q   <= is_mul ? CNT_W'(WIDTH) : rot_n;
            if (!multi_start) begin
              alu_out <= sc_out;
              alu_hi  <= '0;
              E_out   <= sc_e;
              Z_out   <= (sc_out == '0);
            end
          end
        end
        RUN: begin
          work_hi_q <= step_hi;
          work_lo_q <= step_lo;
          work_e_q  <= step_e;
          count_q   <= count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            alu_out <= step_lo;
            Z_out   <= (step_lo == '0);
            if (op_q == OP_MUL) begin
              alu_hi <= step_hi;
              E_out  <= (step_hi != '0);
            end else begin
              alu_hi <= '0;
              E_out  <= step_e;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - table-driven bench for alu_seq at WIDTH 8 and 16
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [3:0] opcode;
  logic [7:0] a, b;
  logic       e;
  logic       busy, done;
  logic [7:0] alu_out, alu_hi;
  logic       e_out, z_out;

  logic        start16;
  logic [3:0]  opcode16;
  logic [15:0] a16, b16;
  logic        e16;
  logic        busy16, done16;
  logic [15:0] alu_out16, alu_hi16;
  logic        e_out16, z_out16;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b), .E(e),
    .busy(busy), .done(done), .alu_out(alu_out), .alu_hi(alu_hi),
    .E_out(e_out), .Z_out(z_out)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .opcode(opcode16), .a(a16), .b(b16), .E(e16),
    .busy(busy16), .done(done16), .alu_out(alu_out16), .alu_hi(alu_hi16),
    .E_out(e_out16), .Z_out(z_out16)
  );

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       e;
    logic [7:0] out;
    logic [7:0] hi;
    logic       eo;
    logic       zo;
    int         lat;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [7:0] va,
                              input logic [7:0] vb, input logic ve, input logic [7:0] out,
                              input logic [7:0] hi, input logic eo, input logic zo, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = va; v.b = vb; v.e = ve;
    v.out = out; v.hi = hi; v.eo = eo; v.zo = zo; v.lat = lat;
    return v;
  endfunction

  task automatic run8(input vec_t v);
    int cyc;
    int busy_n;
    @(negedge clk);
    opcode = v.op; a = v.a; b = v.b; e = v.e; start = 1'b1;
    @(negedge clk);
    start = 1'b0; opcode = 4'b1111; a = ~v.a; b = ~v.b; e = ~v.e;
    cyc = 1; busy_n = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check({v.name, " latency"}, cyc, v.lat);
    check({v.name, " busy_cycles"}, busy_n, v.lat - 1);
    check({v.name, " busy_at_done"}, busy, 1'b0);
    check({v.name, " alu_out"}, alu_out, v.out);
    check({v.name, " alu_hi"}, alu_hi, v.hi);
    check({v.name, " E_out"}, e_out, v.eo);
    check({v.name, " Z_out"}, z_out, v.zo);
    @(negedge clk);
    check({v.name, " done_one_cycle"}, done, 1'b0);
  endtask

  task automatic run16(input string name, input logic [3:0] op, input logic [15:0] va,
                       input logic [15:0] vb, input logic ve, input logic [15:0] out,
                       input logic [15:0] hi, input logic eo, input logic zo, input int lat);
    int cyc;
    @(negedge clk);
    opcode16 = op; a16 = va; b16 = vb; e16 = ve; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = ~va; b16 = ~vb;
    cyc = 1;
    while (!done16 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, cyc, lat);
    check({name, " alu_out"}, alu_out16, out);
    check({name, " alu_hi"}, alu_hi16, hi);
    check({name, " E_out"}, e_out16, eo);
    check({name, " Z_out"}, z_out16, zo);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int dones;

    //          name         op       a      b      e     out    hi     eo    zo   lat
    vecs.push_back(mk("add_f0_20",  4'b0001, 8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1));
    vecs.push_back(mk("sub_05_07",  4'b0010, 8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b0, 1));
    vecs.push_back(mk("sub_07_07",  4'b0010, 8'h07, 8'h07, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1));
    vecs.push_back(mk("inc_ff",     4'b0000, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1));
    vecs.push_back(mk("dec_00",     4'b0011, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1));
    vecs.push_back(mk("and",        4'b0100, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk("ior",        4'b0101, 8'hF0, 8'h0F, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1));
    vecs.push_back(mk("xor",        4'b0110, 8'hAA, 8'hFF, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk("inv",        4'b0111, 8'h0F, 8'h00, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1));
    vecs.push_back(mk("shr_81",     4'b1000, 8'h81, 8'h00, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 1));
    vecs.push_back(mk("shl_81",     4'b1001, 8'h81, 8'h00, 1'b1, 8'h03, 8'h00, 1'b1, 1'b0, 1));
    vecs.push_back(mk("mov_00",     4'b1010, 8'h00, 8'h55, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1));
    vecs.push_back(mk("mul_0f_11",  4'b1011, 8'h0F, 8'h11, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 9));
    vecs.push_back(mk("mul_ff_ff",  4'b1011, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b1, 1'b0, 9));
    vecs.push_back(mk("rcl_81_1",   4'b1101, 8'h81, 8'h01, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 2));
    vecs.push_back(mk("rcr_01_9",   4'b1100, 8'h01, 8'h09, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1));
    vecs.push_back(mk("rcr_01_1",   4'b1100, 8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2));
    vecs.push_back(mk("rcl_00_3",   4'b1101, 8'h00, 8'h03, 1'b1, 8'h04, 8'h00, 1'b0, 1'b0, 4));
    vecs.push_back(mk("rcr_02_10",  4'b1100, 8'h02, 8'h0A, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 2));
    vecs.push_back(mk("op_1110",    4'b1110, 8'hAA, 8'h55, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1));
    vecs.push_back(mk("op_1111",    4'b1111, 8'hAA, 8'h55, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1));
    vecs.push_back(mk("mul_00_37",  4'b1011, 8'h00, 8'h37, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 9));
    vecs.push_back(mk("mul_ff_ff2", 4'b1011, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b1, 1'b0, 9));

    rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0; e = 1'b0;
    start16 = 1'b0; opcode16 = '0; a16 = '0; b16 = '0; e16 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset alu_out", alu_out, 8'h00);
    check("reset alu_hi", alu_hi, 8'h00);
    check("reset E_out", e_out, 1'b0);
    check("reset Z_out", z_out, 1'b1);
    check("reset16 Z_out", z_out16, 1'b1);
    rst = 1'b0;

    foreach (vecs[i]) run8(vecs[i]);

    // MUL with a stray start while busy, then a start during the DONE cycle.
    @(negedge clk);
    opcode = 4'b1011; a = 8'h0F; b = 8'h11; e = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (cyc == 3) begin start = 1'b1; opcode = 4'b0001; a = 8'hF0; b = 8'h20; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("busy_start latency", cyc, 9);
    check("busy_start alu_out", alu_out, 8'hFF);
    check("busy_start E_out", e_out, 1'b0);
    start = 1'b1; opcode = 4'b0001; a = 8'hF0; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("done_cycle_start ignored", dones, 0);
    check("hold alu_out", alu_out, 8'hFF);

    // Abort a MUL in RUN cycle 4 after a prior nonzero result.
    @(negedge clk);
    opcode = 4'b1011; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    check("abort busy before rst", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort alu_out", alu_out, 8'h00);
    check("abort alu_hi", alu_hi, 8'h00);
    check("abort E_out", e_out, 1'b0);
    check("abort Z_out", z_out, 1'b1);
    dones = 0;
    repeat (12) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort no done", dones, 0);

    run16("w16_op_1111", 4'b1111, 16'hAAAA, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1);
    run16("w16_mul_ffff", 4'b1011, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 17);
    run16("w16_add_wrap", 4'b0001, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1);
    run16("w16_rcl_8001", 4'b1101, 16'h8001, 16'h0001, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 2);
    run16("w16_rcr_full", 4'b1100, 16'h0001, 16'h0011, 1'b1, 16'h0001, 16'h0000, 1'b1, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
